// File: rtl/axi_slave_pkg.sv
// Shared encodings for the AXI3 SRAM slave: burst types, response codes
// and the read/write channel FSM state types.
package axi_slave_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rstate_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;

endpackage

// File: rtl/axi_burst_addr.sv
// Next word index of an AXI burst.
//   idx_i   current word index
//   len_i   burst length minus one (WRAP: 1, 3, 7 or 15)
//   burst_i burst type
//   next_o  word index of the following beat
module axi_burst_addr import axi_slave_pkg::*; #(
  parameter int MEM_AW = 12
) (
  input  logic [MEM_AW-1:0] idx_i,
  input  logic [7:0]        len_i,
  input  logic [1:0]        burst_i,
  output logic [MEM_AW-1:0] next_o
);

  logic [MEM_AW-1:0] inc;
  logic [MEM_AW-1:0] mask;
  logic              unused_len;

  assign inc        = idx_i + MEM_AW'(1);
  // legal WRAP lengths are 2^n-1, so len itself is the in-block offset mask
  assign mask       = MEM_AW'(len_i[3:0]);
  assign unused_len = ^len_i[7:4];

  always_comb begin
    next_o = inc;
    case (burst_i)
      BURST_FIXED: next_o = idx_i;
      BURST_WRAP:  next_o = (idx_i & ~mask) | (inc & mask);
      default:     next_o = inc;  // INCR and reserved
    endcase
  end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI3 slave backed by a single-ported 32-bit word memory. Independent read
// and write FSMs, one outstanding transaction each, programmable read latency.
//   aclk/areset          clock, async active-high reset
//   ar*/r*               read address / read data channels
//   aw*/w*/b*            write address / write data / write response channels
//
// state  | meaning
// R_IDLE | arready high, waiting for a read request
// R_WAIT | counting down RD_DELAY before the first beat
// R_DATA | rvalid high, streaming beats
// W_IDLE | awready high, waiting for a write request
// W_DATA | wready high, accepting beats
// W_RESP | bvalid high, waiting for bready
module axi_sram_slave import axi_slave_pkg::*; #(
  parameter int MEM_AW   = 12,
  parameter int RD_DELAY = 0,
  parameter int ID_W     = 4
) (
  input  logic            aclk,
  input  logic            areset,
  input  logic [ID_W-1:0] arid,
  input  logic [31:0]     araddr,
  input  logic [7:0]      arlen,
  input  logic [2:0]      arsize,
  input  logic [1:0]      arburst,
  input  logic [1:0]      arlock,
  input  logic [3:0]      arcache,
  input  logic [2:0]      arprot,
  input  logic            arvalid,
  output logic            arready,
  output logic [ID_W-1:0] rid,
  output logic [31:0]     rdata,
  output logic [1:0]      rresp,
  output logic            rlast,
  output logic            rvalid,
  input  logic            rready,
  input  logic [ID_W-1:0] awid,
  input  logic [31:0]     awaddr,
  input  logic [7:0]      awlen,
  input  logic [2:0]      awsize,
  input  logic [1:0]      awburst,
  input  logic [1:0]      awlock,
  input  logic [3:0]      awcache,
  input  logic [2:0]      awprot,
  input  logic            awvalid,
  output logic            awready,
  input  logic [ID_W-1:0] wid,
  input  logic [31:0]     wdata,
  input  logic [3:0]      wstrb,
  input  logic            wlast,
  input  logic            wvalid,
  output logic            wready,
  output logic [ID_W-1:0] bid,
  output logic [1:0]      bresp,
  output logic            bvalid,
  input  logic            bready
);

  logic [31:0] mem_q [1<<MEM_AW];

  // ---------------- read channel ----------------
  rstate_e           rstate_q, rstate_d;
  logic [ID_W-1:0]   rid_q;
  logic [MEM_AW-1:0] ridx_q, r_next, r_lidx;
  logic [7:0]        rlen_q, rbeat_q, r_lbeat, r_llen;
  logic [1:0]        rburst_q;
  logic [3:0]        rcnt_q;
  logic [31:0]       rdata_q;
  logic              rvalid_q, rlast_q;
  logic              ar_hs, r_hs, r_is_last, r_launch;

  assign arready   = (rstate_q == R_IDLE) && !areset;
  assign ar_hs     = arvalid && arready;
  assign r_hs      = rvalid_q && rready;
  assign r_is_last = (rbeat_q == rlen_q);

  axi_burst_addr #(.MEM_AW(MEM_AW)) u_rd_addr (
    .idx_i(ridx_q), .len_i(rlen_q), .burst_i(rburst_q), .next_o(r_next)
  );

  always_comb begin
    rstate_d = rstate_q;
    r_launch = 1'b0;
    r_lidx   = ridx_q;
    r_lbeat  = 8'd0;
    r_llen   = rlen_q;
    case (rstate_q)
      R_IDLE: if (ar_hs) begin
        if (RD_DELAY == 0) begin
          rstate_d = R_DATA;
          r_launch = 1'b1;
          r_lidx   = araddr[MEM_AW+1:2];
          r_llen   = arlen;
        end else begin
          rstate_d = R_WAIT;
        end
      end
      R_WAIT: if (rcnt_q == 4'd1) begin
        rstate_d = R_DATA;
        r_launch = 1'b1;
      end
      R_DATA: if (r_hs) begin
        if (r_is_last) begin
          rstate_d = R_IDLE;
        end else begin
          r_launch = 1'b1;
          r_lidx   = r_next;
          r_lbeat  = rbeat_q + 8'd1;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rstate_q <= R_IDLE;
      rid_q    <= '0;
      ridx_q   <= '0;
      rlen_q   <= '0;
      rbeat_q  <= '0;
      rburst_q <= '0;
      rcnt_q   <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
    end else begin
      rstate_q <= rstate_d;
      if (ar_hs) begin
        rid_q    <= arid;
        ridx_q   <= araddr[MEM_AW+1:2];
        rlen_q   <= arlen;
        rburst_q <= arburst;
        rbeat_q  <= 8'd0;
        rcnt_q   <= 4'(RD_DELAY);
      end
      if (rstate_q == R_WAIT) rcnt_q <= rcnt_q - 4'd1;
      if (r_launch) begin
        // rdata only changes here, so a stalled beat is never disturbed by writes
        ridx_q   <= r_lidx;
        rbeat_q  <= r_lbeat;
        rdata_q  <= mem_q[r_lidx];
        rvalid_q <= 1'b1;
        rlast_q  <= (r_lbeat == r_llen);
      end else if (r_hs && r_is_last) begin
        rvalid_q <= 1'b0;
        rlast_q  <= 1'b0;
      end
    end
  end

  assign rid    = rid_q;
  assign rdata  = rdata_q;
  assign rresp  = RESP_OKAY;
  assign rlast  = rlast_q;
  assign rvalid = rvalid_q;

  // ---------------- write channel ----------------
  wstate_e           wstate_q, wstate_d;
  logic [ID_W-1:0]   bid_q;
  logic [MEM_AW-1:0] widx_q, w_next;
  logic [7:0]        wlen_q, wbeat_q;
  logic [1:0]        wburst_q, bresp_q;
  logic              werr_q, bvalid_q;
  logic              aw_hs, w_hs, w_at_len, w_end, w_bad, b_hs;

  assign awready  = (wstate_q == W_IDLE) && !areset;
  assign wready   = (wstate_q == W_DATA);
  assign aw_hs    = awvalid && awready;
  assign w_hs     = wvalid && wready;
  assign w_at_len = (wbeat_q == wlen_q);
  // an early wlast truncates the burst; either way a mismatch flags SLVERR
  assign w_end    = w_hs && (wlast || w_at_len);
  assign w_bad    = (wlast != w_at_len);
  assign b_hs     = bvalid_q && bready;

  axi_burst_addr #(.MEM_AW(MEM_AW)) u_wr_addr (
    .idx_i(widx_q), .len_i(wlen_q), .burst_i(wburst_q), .next_o(w_next)
  );

  always_comb begin
    wstate_d = wstate_q;
    case (wstate_q)
      W_IDLE:  if (aw_hs) wstate_d = W_DATA;
      W_DATA:  if (w_end) wstate_d = W_RESP;
      W_RESP:  if (b_hs)  wstate_d = W_IDLE;
      default: wstate_d = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wstate_q <= W_IDLE;
      bid_q    <= '0;
      widx_q   <= '0;
      wlen_q   <= '0;
      wbeat_q  <= '0;
      wburst_q <= '0;
      werr_q   <= 1'b0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
    end else begin
      wstate_q <= wstate_d;
      if (aw_hs) begin
        bid_q    <= awid;
        widx_q   <= awaddr[MEM_AW+1:2];
        wlen_q   <= awlen;
        wburst_q <= awburst;
        wbeat_q  <= 8'd0;
      end
      if (w_hs) begin
        wbeat_q <= wbeat_q + 8'd1;
        widx_q  <= w_next;
        if (w_bad) werr_q <= 1'b1;
      end
      if (w_end) begin
        bvalid_q <= 1'b1;
        bresp_q  <= (werr_q || w_bad) ? RESP_SLVERR : RESP_OKAY;
      end
      if (b_hs) begin
        bvalid_q <= 1'b0;
        werr_q   <= 1'b0;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (w_hs) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) mem_q[widx_q][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign bid    = bid_q;
  assign bresp  = bresp_q;
  assign bvalid = bvalid_q;

  logic unused_ok;
  assign unused_ok = ^{arsize, arlock, arcache, arprot, awsize, awlock, awcache,
                       awprot, wid, araddr[31:MEM_AW+2], araddr[1:0],
                       awaddr[31:MEM_AW+2], awaddr[1:0]};

endmodule

// File: doc/axi_sram_slave.md
Name: axi_sram_slave

Overview:
- AXI3 slave/responder that serves the CPU's AXI master port: single-ported word memory behind independent read and write channel FSMs.
- Used as the memory model in the CPU-level bench and as on-chip RAM in the SoC.
- Supports FIXED, INCR and WRAP bursts (I-Cache line refill is arlen=3, INCR).
- Has a programmable read latency to stress the bridge and cache handshakes.

Parameters:
- MEM_AW, 12, log2 of memory depth in 32-bit words; word index = addr[MEM_AW+1:2], higher address bits alias.
- RD_DELAY, 0, extra idle cycles between AR handshake and first rvalid (0..15).
- ID_W, 4, width of the AXI ID fields.

Ports:
- aclk  in  1  clock, rising edge
- areset  in  1  asynchronous active-high reset
- arid in ID_W; araddr in 32; arlen in 8; arsize in 3; arburst in 2  read address channel
- arlock in 2; arcache in 4; arprot in 3  ignored
- arvalid in 1; arready out 1  read address handshake
- rid out ID_W; rdata out 32; rresp out 2; rlast out 1  read data channel
- rvalid out 1; rready in 1  read data handshake
- awid in ID_W; awaddr in 32; awlen in 8; awsize in 3; awburst in 2  write address channel
- awlock in 2; awcache in 4; awprot in 3  ignored
- awvalid in 1; awready out 1  write address handshake
- wid in ID_W; wdata in 32; wstrb in 4; wlast in 1  write data channel (wid ignored)
- wvalid in 1; wready out 1  write data handshake
- bid out ID_W; bresp out 2; bvalid in/out: bvalid out 1; bready in 1  write response channel

Behaviour:
- Reset (async, immediate): both FSMs to IDLE. Reset values: rvalid=0, bvalid=0, rlast=0, wready=0, rdata=0, rid=0, bid=0, rresp=0, bresp=0.
- Memory contents are not reset. A burst in flight is dropped silently.
- arready=1 iff rstate==R_IDLE and not in reset; awready=1 iff wstate==W_IDLE and not in reset.
- Only one outstanding read and one outstanding write are allowed; the read and write FSMs run concurrently.
- Read FSM states: R_IDLE -> R_WAIT -> R_DATA -> R_IDLE.
  - R_IDLE, on arvalid&arready: latch arid, word index, arlen, arburst; load delay counter with RD_DELAY. Go to R_DATA if RD_DELAY==0, else R_WAIT.
  - R_WAIT: decrement counter; at 0 go to R_DATA. First rvalid is at cycle T+1+RD_DELAY, where T is the AR handshake cycle.
  - R_DATA: rvalid=1, rid=latched id, rresp=2'b00, rlast=(beat==len).
  - rdata is registered and loaded when a beat is launched. It is held stable while rvalid&!rready, even if a write hits the same word.
  - On rvalid&rready: if last beat, go to R_IDLE and clear rvalid/rlast the next cycle; else beat+1, index=next_addr, and the next beat is valid the next cycle (no bubble).
- Write FSM states: W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE, on awvalid&awready: latch awid, index, awlen, awburst; go to W_DATA. W-channel data is never accepted before AW.
  - W_DATA: wready=1. On wvalid&wready, write each byte lane i where wstrb[i]=1 at mem[index] (wstrb=0 writes nothing), then beat+1, index=next_addr.
  - W_DATA, last beat: the beat with beat==len ends the burst, regardless of wlast. If wlast is asserted earlier, the burst ends at that beat and remaining beats are not accepted.
  - Error flag: set if wlast != (beat==len) on any accepted beat.
  - W_RESP: bvalid=1, bid=latched id, bresp=2'b10 (SLVERR) if error flag else 2'b00. Hold until bready; then go to W_IDLE and clear the error flag.
- next_addr uses word indices; arsize/awsize are ignored (always 4 bytes).
  - FIXED (00): unchanged.
  - INCR (01): +1, wraps modulo 2^MEM_AW.
  - WRAP (10): +1 within the aligned block of (len+1) words; len must be 1, 3, 7 or 15.
  - Reserved (11): treated as INCR.
- Simultaneous read-launch and write to the same word in one cycle: the read returns the old data.

Decomposition:
- Package axi_slave_pkg:
  - burst encodings BURST_FIXED/INCR/WRAP
  - response encodings RESP_OKAY=2'b00, RESP_SLVERR=2'b10
  - state enums for the read and write FSMs
- Sub-module axi_burst_addr: combinational next-index calculation (index, len, burst -> next index), instantiated once per channel.

Test Plan:
- Write 0xDEADBEEF to 0x100 (wstrb=4'hF), then a single read with RD_DELAY=0 -> rvalid at T+1, rdata=0xDEADBEEF, rlast=1, rid=arid, rresp=0.
- Preload words 0x200..0x20C, 4-beat INCR read with rready low for 3 cycles at beat 1 -> rdata stable while stalled, 4 beats in order, rlast only on beat 3.
- Write 0x11223344 to 0x300, then wstrb=4'b0101 with 0xAABBCCDD -> readback 0x11BB33DD; bresp=0, bid=awid.
- WRAP 4-beat read at 0x408 (RD_DELAY=3) -> first rvalid at T+4, word order 0x408, 0x40C, 0x400, 0x404.
- 4-beat write with wlast on beat 1 -> only 2 words written, bresp=2'b10; the next clean write returns bresp=0.
- Assert areset during beat 2 of an 8-beat read -> rvalid=0 immediately, arready=1 after release, and a new read completes correctly.
